// File: rtl/rca_seq_pkg.sv
// Shared definitions for the nibble-serial ripple-carry sequencer.
// Holds the FSM state encoding and the adder slice width.
package rca_seq_pkg;

  // Width of the shared ripple adder slice
  localparam int NIBBLE_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_serial_seq_rca.sv
// rca: 4-bit ripple-carry adder, the single datapath slice reused every
// cycle by rca_serial_seq. Pure combinational full-adder chain.
module rca
  import rca_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // c[i] is the carry into bit i; c[NIBBLE_W] leaves the slice
  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/rca_serial_seq.sv
// rca_serial_seq: adds two W-bit operands (W = 4*NIBBLES) through one
// shared 4-bit ripple adder, one nibble per cycle, LSB nibble first.
// The inter-nibble carry lives in carry_q.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. req_ready is high only in IDLE, rsp_valid only in
// DONE; there is never a request accept in the cycle of a response
// handshake.
//
// Optional build macro RCA_SERIAL_SEQ_SUB_EN adds req_sub (subtract:
// invert B, force nibble-0 carry-in to 1) and rsp_ovf (signed overflow
// of the top nibble).
module rca_serial_seq
  import rca_seq_pkg::*;
#(
  parameter int  NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
`ifdef RCA_SERIAL_SEQ_SUB_EN
  input  logic         req_sub,
`endif
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
`ifdef RCA_SERIAL_SEQ_SUB_EN
  output logic         rsp_ovf,
`endif
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic [W-1:0]         sum_q;
  logic                 carry_q;
  logic                 cout_q;
  logic [IDX_W-1:0]     idx_q;

  logic                 accept;
  logic                 in_run;
  logic                 last_nib;
  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  add_sum;
  logic                 add_cout;

`ifdef RCA_SERIAL_SEQ_SUB_EN
  logic                 sub_q;
  logic                 ovf_q;
  logic                 ovf_nib;
`endif

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign in_run   = (state_q == ST_RUN);
  assign last_nib = in_run && (idx_q == LAST_IDX);

  // Current nibble of each operand; B is inverted for subtraction
  assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
`ifdef RCA_SERIAL_SEQ_SUB_EN
  assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
`else
  assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
`endif

  rca u_rca (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef RCA_SERIAL_SEQ_SUB_EN
  // Carry into the slice MSB is recovered from its sum bit, so the adder
  // slice keeps a plain interface; overflow = c_in(msb) ^ c_out(msb)
  assign ovf_nib = (a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ add_sum[NIBBLE_W-1])
                   ^ add_cout;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last
  // nibble, DONE -> IDLE on response handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid)           state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX)   state_d = ST_DONE;
      ST_DONE: if (rsp_ready)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Operand capture, nibble index, carry and result registers. The
  // nibble-0 carry-in is preloaded into carry_q at accept so every RUN
  // cycle uses the same adder input path.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef RCA_SERIAL_SEQ_SUB_EN
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= req_a;
      b_q     <= req_b;
      idx_q   <= '0;
`ifdef RCA_SERIAL_SEQ_SUB_EN
      sub_q   <= req_sub;
      carry_q <= req_sub ? 1'b1 : req_cin;
`else
      carry_q <= req_cin;
`endif
    end else if (in_run) begin
      sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= add_sum;
      carry_q <= add_cout;
      if (last_nib) begin
        cout_q <= add_cout;
`ifdef RCA_SERIAL_SEQ_SUB_EN
        ovf_q  <= ovf_nib;
`endif
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign dbg_state = state_q;
`ifdef RCA_SERIAL_SEQ_SUB_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule
